// File: rtl/register_pipe.sv
// register_pipe: WIDTH-bit, DEPTH-stage pipeline register chain with a
// valid/ready handshake on both sides.
//
// Every stage advances on its own. A word moves forward whenever the stage
// ahead is empty or is emptying on the same edge. Bubbles therefore collapse,
// and the chain holds up to DEPTH words while the consumer stalls.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        synchronous reset, active-high; clears valids, data <= RESET_VAL
//   flush      synchronous clear of all in-flight words; data registers kept
//   in_valid   producer has a word on in_data
//   in_ready   pipe accepts a word this cycle (low while flush or rst)
//   in_data    producer word
//   out_valid  last stage holds a valid word
//   out_ready  consumer takes out_data this cycle
//   out_data   data register of the last stage
//   occupancy  registered count of valid stages
module register_pipe #(
  parameter int                WIDTH     = 8,
  parameter int                DEPTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  localparam int               OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] enter;
  logic [DEPTH-1:0] leave;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  always_comb begin
    // Readiness chain: rdy[i] means stage i can take a word this edge.
    // rdy[DEPTH] stands for the consumer, which keeps the chain uniform.
    // Kept local so the chain is evaluated as ordered statements.
    logic [DEPTH:0] rdy;
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = !valid_q[i] | rdy[i+1];
    end

    in_ready = rdy[0] & !flush & !rst;

    leave = '0;
    for (int i = 0; i < DEPTH; i++) begin
      leave[i] = valid_q[i] & rdy[i+1];
    end

    enter    = '0;
    enter[0] = in_valid & in_ready;
    for (int i = 1; i < DEPTH; i++) begin
      enter[i] = leave[i-1];
    end

    // A stage that is refilled on the same edge it drains stays valid.
    valid_d = (valid_q & ~leave) | enter;

    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OCC_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
    end else if (flush) begin
      // Data registers are left alone. out_data keeps showing the last word.
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      if (enter[0]) begin
        data_q[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (enter[i]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: doc/register_pipe.md
Name: register_pipe

Overview:
- Parametrised successor to the team's single 8-bit register: a WIDTH-bit, DEPTH-stage pipeline register chain with valid/ready handshake on both sides.
- Each stage advances independently, so bubbles collapse and data is held under backpressure without loss.
- Sits between producer and consumer blocks to add retiming stages and absorb up to DEPTH words of stall.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of register stages (>=1).
- RESET_VAL, 0, value loaded into every stage data register on reset (WIDTH bits).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  synchronous clear of all in-flight words.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  pipe can accept a word this cycle.
- in_data  input  WIDTH  producer word.
- out_valid  output  1  stage DEPTH-1 holds a valid word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  WIDTH  data register of stage DEPTH-1.
- occupancy  output  OCC_W  registered count of valid stages; OCC_W = $clog2(DEPTH+1) (3 for DEPTH=4).

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- State per stage i (0..DEPTH-1): valid[i], data[i]. Stage 0 is the input stage; stage DEPTH-1 drives out_data/out_valid.
- Reset (rst=1 at edge): all valid[i]=0, all data[i]=RESET_VAL, occupancy=0. Resulting outputs: out_valid=0, out_data=RESET_VAL, in_ready=1, once rst is low.
- Stage readiness (combinational): rdy[DEPTH-1] = !valid[DEPTH-1] | out_ready; rdy[i] = !valid[i] | rdy[i+1].
- in_ready = rdy[0] & !flush & !rst.
- Transfers at an edge:
  - Input accept when in_valid & in_ready: data[0] <= in_data, valid[0] <= 1.
  - Stage i to i+1 when valid[i] & rdy[i+1]: data[i+1] <= data[i], valid[i+1] <= 1.
  - Output when out_valid & out_ready: valid[DEPTH-1] cleared unless refilled the same edge.
- Data registers load only on a transfer into that stage. A held word's data is stable bit-for-bit while stalled.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N+DEPTH-1. That is, DEPTH cycles from the in_valid&in_ready cycle to the first out_valid cycle, provided no downstream stall.
- Throughput: 1 word/cycle sustained when out_ready=1. in_ready stays 1 when full and out_ready=1 (pass-through stall-free).
- Ordering: strict FIFO order. No duplication, no drop, except by flush or reset.
- Bubble collapse: an empty stage accepts from upstream even if downstream is stalled. Full capacity is DEPTH words regardless of arrival gaps.
- Full: occupancy==DEPTH and out_ready=0 → in_ready=0.
- Empty: occupancy==0 → out_valid=0, out_data holds its last value.
- Flush (flush=1 at edge, rst=0): all valid[i] <= 0, occupancy <= 0, data registers unchanged.
  - in_ready=0 during the flush cycle, so no word is accepted.
  - If out_valid&out_ready in the flush cycle, that output transfer counts as completed.
- Priority: rst > flush > normal transfers.
- occupancy: registered, equals the popcount of valid[] after each edge. Accept and output in the same edge leaves it unchanged.
- Reset mid-operation: all in-flight words are discarded; behaviour is identical to power-up reset.
- in_data and in_valid are don't-care while in_ready=0 or rst=1.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in_data=0x5A → out_valid=0, out_data=0x00, occupancy=0 throughout. After rst=0, in_ready=1 and 0x5A is not present in the pipe.
- Streaming (DEPTH=4, out_ready=1): push 0x11,0x22,…,0xAA on 10 consecutive cycles → first out_valid 4 cycles after the 0x11 accept. Outputs 0x11..0xAA on 10 consecutive cycles, in_ready=1 throughout.
- Backpressure: out_ready=0, offer 0x11..0x66 back-to-back → 0x11..0x44 accepted, in_ready=0 from the 5th cycle, occupancy=4, out_data=0x11 stable. Then out_ready=1 → outputs 0x11,0x22,0x33,0x44,0x55,0x66 in order with no gaps.
- Bubble collapse: out_ready=0; push 0x11, idle 3 cycles, push 0x22, idle 2, push 0x33 → occupancy=3, out_data=0x11. After out_ready=1, outputs 0x11,0x22,0x33 on consecutive cycles.
- Flush: 3 words (0x11,0x22,0x33) in flight, out_ready=0. Assert flush one cycle with in_valid=1, in_data=0x55 → next cycle occupancy=0, out_valid=0, and 0x55 never emerges. Then push 0x66 → out_valid with 0x66 exactly 4 cycles later.
- Parameter corners: DEPTH=1, WIDTH=16, RESET_VAL=0xBEEF → after reset out_data=0xBEEF. Push 0x1234 with out_ready=1 → out_valid the next cycle. Simultaneous pop and push of 0x5678 keeps in_ready=1 and occupancy=1.
